// File: rtl/fetch_stage.sv
// Fetch stage with IF/ID register: in-order variable-latency instruction fetch through a DEPTH-entry queue.
// Optional feature: define FETCH_BYPASS_EN to load a returning word straight into IF/ID when the queue is empty.
module fetch_stage #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] NOP      = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = PW + 1;
  localparam logic [CW:0]   depthLim = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] ptrOne   = PW'(1);
  localparam logic [CW-1:0] cntOne   = CW'(1);
  localparam logic [CW-1:0] cntZero  = {CW{1'b0}};
  localparam logic [PW-1:0] ptrZero  = {PW{1'b0}};

  logic [31:0]   pcF;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] dropCnt;
  logic [CW-1:0] count;
  logic [PW-1:0] qWr;
  logic [PW-1:0] qRd;
  logic [PW-1:0] tWr;
  logic [PW-1:0] tRd;
  logic [31:0]   qInstr [DEPTH];
  logic [31:0]   qPc    [DEPTH];
  logic [31:0]   tagMem [DEPTH];

  logic          accept;
  logic          dropWord;
  logic          rspTake;
  logic          pushQ;
  logic          popQ;
  logic          bypass;
  logic [CW:0]   inFlight;
  logic [CW-1:0] rvalidExt;
  logic [CW-1:0] acceptExt;

  assign imem_addr = pcF;

  // Issue, drop and queue-handshake decisions for the current cycle
  always_comb begin
    inFlight  = {1'b0, outstanding} + {1'b0, count};
    imem_req  = reset & ~StallF & ~PCSrcD & (inFlight < depthLim);
    accept    = imem_req & imem_ready;
    dropWord  = imem_rvalid & (dropCnt != cntZero);
    rspTake   = imem_rvalid & ~dropWord & ~PCSrcD;
    popQ      = ~PCSrcD & ~StallD & (count != cntZero);
`ifdef FETCH_BYPASS_EN
    bypass    = rspTake & ~StallD & (count == cntZero);
`else
    bypass    = 1'b0;
`endif
    pushQ     = rspTake & ~bypass;
    rvalidExt = imem_rvalid ? cntOne : cntZero;
    acceptExt = accept ? cntOne : cntZero;
  end

  // Fetch PC, outstanding-request count and stale-response drop count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcF         <= RESET_PC;
      outstanding <= cntZero;
      dropCnt     <= cntZero;
    end else begin
      if (PCSrcD) begin
        pcF <= PCBranchD;
      end else if (accept) begin
        pcF <= pcF + 32'd4;
      end
      outstanding <= outstanding + acceptExt - rvalidExt;
      // Everything still in flight at a redirect belongs to the old path
      if (PCSrcD) begin
        dropCnt <= outstanding - rvalidExt;
      end else if (dropWord) begin
        dropCnt <= dropCnt - cntOne;
      end
    end
  end

  // In-order tag FIFO holding PC+4 of every live outstanding request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tWr <= ptrZero;
      tRd <= ptrZero;
      for (int i = 0; i < DEPTH; i++) tagMem[i] <= 32'h0;
    end else if (PCSrcD) begin
      tWr <= ptrZero;
      tRd <= ptrZero;
    end else begin
      if (accept) begin
        tagMem[tWr] <= pcF + 32'd4;
        tWr         <= tWr + ptrOne;
      end
      if (rspTake) begin
        tRd <= tRd + ptrOne;
      end
    end
  end

  // Fetch queue of returned {instruction, PC+4} pairs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qWr   <= ptrZero;
      qRd   <= ptrZero;
      count <= cntZero;
      for (int i = 0; i < DEPTH; i++) begin
        qInstr[i] <= 32'h0;
        qPc[i]    <= 32'h0;
      end
    end else if (PCSrcD) begin
      qWr   <= ptrZero;
      qRd   <= ptrZero;
      count <= cntZero;
    end else begin
      if (pushQ) begin
        qInstr[qWr] <= imem_rdata;
        qPc[qWr]    <= tagMem[tRd];
        qWr         <= qWr + ptrOne;
      end
      if (popQ) begin
        qRd <= qRd + ptrOne;
      end
      case ({pushQ, popQ})
        2'b10:   count <= count + cntOne;
        2'b01:   count <= count - cntOne;
        default: count <= count;
      endcase
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      InstrD   <= NOP;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else if (PCSrcD) begin
      InstrD <= NOP;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (popQ) begin
        InstrD   <= qInstr[qRd];
        PCPlus4D <= qPc[qRd];
        ValidD   <= 1'b1;
      end else if (bypass) begin
        InstrD   <= imem_rdata;
        PCPlus4D <= tagMem[tRd];
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP;
        ValidD <= 1'b0;
      end
    end
  end

endmodule
